lsu_dccm_req_ctl: RTL and testbench

//  Initiator-side controller for the DCCM port pins of the memory wrapper.

---
 rtl/lsu_dccm_req_ctl_if.sv | 68 ++++++
 rtl/lsu_dccm_req_ctl.sv | 134 +++++++++++++
 tb/tb_lsu_dccm_req_ctl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_dccm_req_ctl_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : lsu_dccm_req_ctl_if
// Purpose  : Bundles the request, response and DCCM pin signals of the
//            LSU-to-DCCM request controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
// Signals
//   req_valid/req_ready      request handshake (LSU -> controller)
//   req_write                1=store, 0=load
//   req_addr[DCCM_BITS]      byte address, [1:0] ignored
//   req_wdata[DATA_W]        store data
//   req_be[DATA_W/8]         store byte enables
//   rsp_valid/rsp_ready      response handshake (controller -> LSU)
//   rsp_rdata[DATA_W]        load data, 0 for stores
//   dccm_rden/dccm_wren      DCCM read / write strobes
//   dccm_rd_addr_lo/hi       DCCM read address (identical copies)
//   dccm_wr_addr             DCCM write address
//   dccm_wr_data             DCCM write data
//   dccm_rd_data_lo          DCCM read data, valid the cycle after dccm_rden
// Modports
//   master : the controller (drives ready/response/DCCM strobes)
//   slave  : the surrounding LSU pipe and DCCM array
//------------------------------------------------------------------------------
interface lsu_dccm_req_ctl_if #(
  parameter int DCCM_BITS = 16,
  parameter int DATA_W    = 32
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_write;
  logic [DCCM_BITS-1:0]   req_addr;
  logic [DATA_W-1:0]      req_wdata;
  logic [DATA_W/8-1:0]    req_be;

  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [DATA_W-1:0]      rsp_rdata;

  logic                   dccm_rden;
  logic                   dccm_wren;
  logic [DCCM_BITS-1:0]   dccm_rd_addr_lo;
  logic [DCCM_BITS-1:0]   dccm_rd_addr_hi;
  logic [DCCM_BITS-1:0]   dccm_wr_addr;
  logic [DATA_W-1:0]      dccm_wr_data;
  logic [DATA_W-1:0]      dccm_rd_data_lo;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_be,
    output req_ready,
    output rsp_valid, rsp_rdata,
    input  rsp_ready,
    output dccm_rden, dccm_wren, dccm_rd_addr_lo, dccm_rd_addr_hi,
    output dccm_wr_addr, dccm_wr_data,
    input  dccm_rd_data_lo
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_be,
    input  req_ready,
    input  rsp_valid, rsp_rdata,
    output rsp_ready,
    input  dccm_rden, dccm_wren, dccm_rd_addr_lo, dccm_rd_addr_hi,
    input  dccm_wr_addr, dccm_wr_data,
    output dccm_rd_data_lo
  );
endinterface
`default_nettype wire

// File: rtl/lsu_dccm_req_ctl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : lsu_dccm_req_ctl
// Purpose  : Initiator-side DCCM request controller. Accepts one load/store
//            at a time, sequences dccm_rden/dccm_wren, performs
//            read-modify-write for partial stores and returns exactly one
//            response per request.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports
//   clk  in  core clock
//   rst  in  synchronous reset, active-high
//   bus  lsu_dccm_req_ctl_if.master - request/response handshakes and the
//        DCCM pins (see interface header for the signal list)
//------------------------------------------------------------------------------
module lsu_dccm_req_ctl #(
  parameter int DCCM_BITS = 16,
  parameter int DATA_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  lsu_dccm_req_ctl_if.master    bus
);

  localparam int BE_W = DATA_W / 8;
  // Forces word alignment when the address is captured.
  localparam logic [DCCM_BITS-1:0] ADDR_MASK = {{(DCCM_BITS-2){1'b1}}, 2'b00};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_RD_CAP  = 3'd2,
    ST_RMW_RD  = 3'd3,
    ST_RMW_CAP = 3'd4,
    ST_WR      = 3'd5,
    ST_RSP     = 3'd6
  } state_e;

  state_e                 state_q, state_d;
  logic [DCCM_BITS-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;     // store data, later the merged word
  logic [BE_W-1:0]        be_q, be_d;
  logic [DATA_W-1:0]      rsp_rdata_q, rsp_rdata_d;
  logic                   rden_q, rden_d;
  logic                   wren_q, wren_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]      merged_data;

  // Byte-lane merge of the store data over the word just read back.
  for (genvar i = 0; i < BE_W; i++) begin : g_lane
    assign merged_data[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8]
                                           : bus.dccm_rd_data_lo[8*i +: 8];
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rsp_rdata_d = rsp_rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          addr_d      = bus.req_addr & ADDR_MASK;
          wdata_d     = bus.req_wdata;
          be_d        = bus.req_be;
          rsp_rdata_d = '0;               // store responses carry zero data
          if (!bus.req_write)      state_d = ST_RD;
          else if (&bus.req_be)    state_d = ST_WR;
          else if (|bus.req_be)    state_d = ST_RMW_RD;
          else                     state_d = ST_RSP;   // nothing to write
        end
      end
      ST_RD:      state_d = ST_RD_CAP;
      ST_RD_CAP: begin
        rsp_rdata_d = bus.dccm_rd_data_lo;
        state_d     = ST_RSP;
      end
      ST_RMW_RD:  state_d = ST_RMW_CAP;
      ST_RMW_CAP: begin
        wdata_d = merged_data;
        state_d = ST_WR;
      end
      ST_WR:      state_d = ST_RSP;
      ST_RSP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default:    state_d = ST_IDLE;
    endcase

    // Strobes are decoded from the next state so they leave a flop aligned
    // with the state they belong to.
    rden_d      = (state_d == ST_RD) || (state_d == ST_RMW_RD);
    wren_d      = (state_d == ST_WR);
    rsp_valid_d = (state_d == ST_RSP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rsp_rdata_q <= '0;
      rden_q      <= 1'b0;
      wren_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rsp_rdata_q <= rsp_rdata_d;
      rden_q      <= rden_d;
      wren_q      <= wren_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Gated by rst so the port reads 0 while reset is held and 1 as soon as
  // it is released.
  assign bus.req_ready       = (state_q == ST_IDLE) && !rst;
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_rdata       = rsp_rdata_q;
  assign bus.dccm_rden       = rden_q;
  assign bus.dccm_wren       = wren_q;
  assign bus.dccm_rd_addr_lo = addr_q;
  assign bus.dccm_rd_addr_hi = addr_q;
  assign bus.dccm_wr_addr    = addr_q;
  assign bus.dccm_wr_data    = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_dccm_req_ctl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_lsu_dccm_req_ctl
// Purpose  : Self-checking bench for lsu_dccm_req_ctl: directed scenarios
//            followed by randomized loads/stores compared against a
//            word-level reference memory.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_lsu_dccm_req_ctl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_dccm_req_ctl_if #(.DCCM_BITS(16), .DATA_W(32)) bus ();
  lsu_dccm_req_ctl #(.DCCM_BITS(16), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // DCCM array model (64 words, indexed by address bits [7:2]).
  logic        mem_clr;
  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];

  // Strobe monitor.
  int          rden_cnt    = 0;
  int          wren_cnt    = 0;
  int          overlap_cnt = 0;
  logic [15:0] last_rd_lo, last_rd_hi, last_wr_addr;
  logic [31:0] last_wr_data;

  function automatic logic [31:0] seed_word(input int i);
    return (32'h0100_0193 * (i + 1)) ^ 32'hA5A5_5A5A;
  endfunction

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= seed_word(i);
    end else if (bus.dccm_wren) begin
      mem[bus.dccm_wr_addr[7:2]] <= bus.dccm_wr_data;
    end
    // Junk outside the read-return cycle exposes mistimed captures.
    if (bus.dccm_rden) bus.dccm_rd_data_lo <= mem[bus.dccm_rd_addr_lo[7:2]];
    else               bus.dccm_rd_data_lo <= $urandom;
  end

  always @(negedge clk) begin
    if (bus.dccm_rden) begin
      rden_cnt++;
      last_rd_lo = bus.dccm_rd_addr_lo;
      last_rd_hi = bus.dccm_rd_addr_hi;
    end
    if (bus.dccm_wren) begin
      wren_cnt++;
      last_wr_addr = bus.dccm_wr_addr;
      last_wr_data = bus.dccm_wr_data;
    end
    if (bus.dccm_rden && bus.dccm_wren) overlap_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete request/response exchange. Called and returns at a negedge.
  task automatic do_txn(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int hold, input string name);
    int          exp_lat, exp_rd, exp_wr, k, r0, w0;
    logic [31:0] exp_rdata, exp_word;
    logic [5:0]  idx;
    idx       = addr[7:2];
    exp_word  = ref_mem[idx];
    exp_rdata = 32'h0;
    if (!wr) begin
      exp_lat = 3; exp_rd = 1; exp_wr = 0; exp_rdata = ref_mem[idx];
    end else if (be == 4'hF) begin
      exp_lat = 2; exp_rd = 0; exp_wr = 1; exp_word = wdata;
    end else if (be == 4'h0) begin
      exp_lat = 1; exp_rd = 0; exp_wr = 0;
    end else begin
      exp_lat = 4; exp_rd = 1; exp_wr = 1;
      for (int b = 0; b < 4; b++) if (be[b]) exp_word[8*b +: 8] = wdata[8*b +: 8];
    end
    r0 = rden_cnt;
    w0 = wren_cnt;

    check({name, ".req_ready_idle"}, bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom);
    bus.req_addr  = 16'($urandom);
    bus.req_wdata = $urandom;
    bus.req_be    = 4'($urandom);

    k = 1;
    while (!bus.rsp_valid && k < 12) begin
      @(negedge clk);
      k++;
    end
    check({name, ".latency"}, k, exp_lat);
    if (!bus.rsp_valid) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      return;
    end
    check({name, ".rsp_rdata"}, bus.rsp_rdata, exp_rdata);
    check({name, ".req_ready_busy"}, bus.req_ready, 0);

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({name, ".hold_valid"}, bus.rsp_valid, 1);
      check({name, ".hold_rdata"}, bus.rsp_rdata, exp_rdata);
      check({name, ".hold_req_ready"}, bus.req_ready, 0);
    end

    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check({name, ".rsp_done"}, bus.rsp_valid, 0);
    check({name, ".req_ready_back"}, bus.req_ready, 1);
    check({name, ".rden_count"}, rden_cnt - r0, exp_rd);
    check({name, ".wren_count"}, wren_cnt - w0, exp_wr);
    if (exp_rd != 0) begin
      check({name, ".rd_addr_lo"}, last_rd_lo, addr & 16'hFFFC);
      check({name, ".rd_addr_hi"}, last_rd_hi, addr & 16'hFFFC);
    end
    if (exp_wr != 0) begin
      check({name, ".wr_addr"}, last_wr_addr, addr & 16'hFFFC);
      check({name, ".wr_data"}, last_wr_data, exp_word);
    end
    ref_mem[idx] = exp_word;
    check({name, ".mem_word"}, mem[idx], ref_mem[idx]);
  endtask

  initial begin
    int          w0;
    int          sel;
    logic [3:0]  rbe;

    rst           = 1'b1;
    mem_clr       = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 16'h0;
    bus.req_wdata = 32'h0;
    bus.req_be    = 4'h0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = seed_word(i);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.req_ready", bus.req_ready, 0);
    check("reset.rsp_valid", bus.rsp_valid, 0);
    check("reset.rsp_rdata", bus.rsp_rdata, 0);
    check("reset.rden", bus.dccm_rden, 0);
    check("reset.wren", bus.dccm_wren, 0);
    check("reset.wr_addr", bus.dccm_wr_addr, 0);
    check("reset.wr_data", bus.dccm_wr_data, 0);
    rst     = 1'b0;
    mem_clr = 1'b0;
    #1;
    check("reset.req_ready_after", bus.req_ready, 1);
    @(negedge clk);

    // Directed scenarios.
    do_txn(1'b1, 16'h0013, 32'hDEADBEEF, 4'hF, 0, "full_st");
    do_txn(1'b0, 16'h0010, 32'h0, 4'h0, 5, "ld_hold");
    do_txn(1'b1, 16'h0010, 32'h0000AB00, 4'b0010, 0, "part_st");
    check("part_st.merged", mem[4], 32'hDEADABEF);
    do_txn(1'b1, 16'h0020, $urandom, 4'h0, 1, "be0_st");

    // Reset while the merged word is being formed: write must be abandoned.
    w0 = wren_cnt;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 16'h0012;
    bus.req_wdata = 32'h11223344;
    bus.req_be    = 4'b0101;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("rmw_rst.rmw_rden", bus.dccm_rden, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rmw_rst.wren", bus.dccm_wren, 0);
    check("rmw_rst.rden", bus.dccm_rden, 0);
    check("rmw_rst.rsp_valid", bus.rsp_valid, 0);
    check("rmw_rst.rsp_rdata", bus.rsp_rdata, 0);
    check("rmw_rst.wr_data", bus.dccm_wr_data, 0);
    check("rmw_rst.wr_addr", bus.dccm_wr_addr, 0);
    check("rmw_rst.req_ready_in_rst", bus.req_ready, 0);
    rst = 1'b0;
    #1;
    check("rmw_rst.req_ready_after", bus.req_ready, 1);
    repeat (3) begin
      @(negedge clk);
      check("rmw_rst.quiet_rsp", bus.rsp_valid, 0);
    end
    check("rmw_rst.wren_count", wren_cnt - w0, 0);
    check("rmw_rst.mem_intact", mem[4], ref_mem[4]);

    // Randomized traffic over a small window so loads see earlier stores.
    for (int t = 0; t < 60; t++) begin
      sel = int'($urandom_range(0, 3));
      if (sel == 0)      rbe = 4'hF;
      else if (sel == 1) rbe = 4'h0;
      else               rbe = 4'($urandom);
      do_txn(1'($urandom_range(0, 1)), 16'($urandom), $urandom, rbe,
             int'($urandom_range(0, 3)), "rand");
    end

    check("strobe_overlap", overlap_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
